p2s_serial_rx: RTL and testbench

//  Serial-to-parallel receiver: the far end of the p2s serial output line (sdata).

---
 rtl/p2s_serial_rx.sv | 108 ++++++++++
 tb/tb_p2s_serial_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/p2s_serial_rx.sv
// p2s_serial_rx: serial-to-parallel receiver for the p2s line.
// Frame: start(0), DATA_W data bits LSB first, optional parity, stop(1).
// Received words are offered on a valid/ready port through a 1-entry buffer.
module p2s_serial_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdata,
    output logic [DATA_W-1:0] pdata,
    output logic              pvalid,
    input  logic              pready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    logic [1:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_next;
    logic              par_err_q;
    logic              word_done;
    logic              take;

    // Next shift value: new bit enters at the MSB so the first bit ends at the LSB.
    always_comb begin
        shift_next = shift_q;
        for (int unsigned i = 0; i + 1 < DATA_W; i++) begin
            shift_next[i] = shift_q[i+1];
        end
        shift_next[DATA_W-1] = sdata;
    end

    assign word_done = (state == S_STOP) && sdata;
    assign take      = !pvalid || pready;
    assign busy      = (state != S_IDLE);

    // Frame FSM: start detect, data assembly, parity evaluation, stop check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!sdata) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    shift_q <= shift_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_err_q <= (((^shift_q) ^ sdata) != PARITY_ODD);
                    state     <= S_STOP;
                end
                S_STOP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output buffer and error pulses; a word arriving while the buffer is stuck is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdata      <= '0;
            pvalid     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= (state == S_STOP) && !sdata;
            overrun   <= word_done && !take;
            if (word_done && take) begin
                pdata      <= shift_q;
                parity_err <= PARITY_EN ? par_err_q : 1'b0;
                pvalid     <= 1'b1;
            end else if (pvalid && pready) begin
                pvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_p2s_serial_rx.sv
// Scoreboard bench for p2s_serial_rx (DATA_W=8, even parity).
module tb_p2s_serial_rx;

    logic       clk;
    logic       rst;
    logic       sdata;
    logic [7:0] pdata;
    logic       pvalid;
    logic       pready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [8:0] exp_q[$];   // {parity_err, pdata} expected at each handshake
    chk_t       dq[$];      // direct comparisons raised by the stimulus process
    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    p2s_serial_rx #(
        .DATA_W    (8),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sdata     (sdata),
        .pdata     (pdata),
        .pvalid    (pvalid),
        .pready    (pready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts error pulses, checks handshakes against the scoreboard.
    always @(negedge clk) begin
        chk_t       r;
        logic [8:0] e;
        while (dq.size() > 0) begin
            r = dq.pop_front();
            checks++;
            if (r.act !== r.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", r.name, r.act, r.exp);
            end
        end
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (pvalid && pready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got pdata=%h parity_err=%b expected no word",
                             pdata, parity_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({parity_err, pdata} !== e) begin
                        errors++;
                        $display("FAIL word: got pdata=%h parity_err=%b expected pdata=%h parity_err=%b",
                                 pdata, parity_err, e[7:0], e[8]);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t r;
        r.name = n;
        r.act  = a;
        r.exp  = e;
        dq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 11-bit frame; flip inverts the correct even parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              input bit expect_word);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = d;
        bits[9]    = (^d) ^ flip;
        bits[10]   = stop;
        if (expect_word) exp_q.push_back({flip, d});
        for (int i = 0; i < 11; i++) begin
            sdata = bits[i];
            tick();
        end
        sdata = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        sdata  = 1'b1;
        pready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_pvalid", 32'(pvalid), 32'd0);
        chk("rst_pdata", 32'(pdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: clean A5 frame
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        drain();

        // 2: A5 with wrong parity, still delivered
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        drain();
        chk("t2_no_frame_err", 32'(fe_cnt), 32'd0);

        // 3: stop bit 0 -> single frame_err cycle, no word
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("t3_frame_err", 32'(fe_cnt), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_pvalid", 32'(pvalid), 32'd0);

        // 4: consumer stalled, back-to-back 01 then 02
        pready = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("t4_overrun", 32'(ov_cnt), 32'd1);
        chk("t4_pvalid_held", 32'(pvalid), 32'd1);
        chk("t4_pdata_held", 32'(pdata), 32'h01);
        chk("t4_no_frame_err", 32'(fe_cnt), 32'd1);
        pready = 1'b1;
        drain();

        // 5: reset in the middle of a frame
        sdata = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            sdata = (i % 2 == 0);
            tick();
        end
        chk("t5_busy_before", 32'(busy), 32'd1);
        sdata = 1'b1;
        rst   = 1'b1;
        #1;
        chk("t5_pdata", 32'(pdata), 32'd0);
        chk("t5_pvalid", 32'(pvalid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        drain();

        // 6: zero idle gap between FF and 00
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        drain();
        repeat (2) tick();
        chk("end_frame_err", 32'(fe_cnt), 32'd1);
        chk("end_overrun", 32'(ov_cnt), 32'd1);

        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
